mem_request_unit: RTL and testbench

Processor-side request front end for the direct-mapped cache subsystem. It accepts load/store requests over a valid/ready handshake, buffers them in a small FIFO, and drives them one at a time onto the cache's `fulladdress`/`read_signal`/`write_signal`/`out_write` inputs. It holds each request stable until the cache's `state` output shows the access has completed, then returns read data (or a timeout error) over a valid/ready response channel. It sits directly upstream of the cache top level.

---
 rtl/mem_req_pkg.sv | 22 ++
 rtl/req_fifo.sv | 54 +++++
 rtl/mem_request_unit.sv | 170 +++++++++++++++++
 tb/tb_mem_request_unit.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_req_pkg.sv
// Shared types for the cache request front end: FSM encoding, cache idle code and FIFO entry.
package mem_req_pkg;

    localparam int unsigned MEM_BITS = 5;
    localparam int unsigned MEM_SIZE = 32;

    localparam logic [3:0] CACHE_IDLE = 4'd0;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StResp
    } req_state_e;

    typedef struct packed {
        logic                write;
        logic [MEM_BITS-1:0] addr;
        logic [MEM_SIZE-1:0] wdata;
    } req_entry_t;

endpackage

// File: rtl/req_fifo.sv
// Small synchronous FIFO with occupancy count; DEPTH must be a power of two so pointers wrap
// naturally.
module req_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam logic [PtrW:0] FullCount = (PtrW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]    count_q;
    logic             do_push, do_pop;

    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign full     = (count_q == FullCount);
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: emptiness is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/mem_request_unit.sv
// Processor-side request front end: buffers load/store requests and sequences them one at a
// time onto the direct-mapped cache, returning read data or a timeout error.
module mem_request_unit
    import mem_req_pkg::*;
#(
    parameter int unsigned memory_bits = MEM_BITS,
    parameter int unsigned memory_size = MEM_SIZE,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned TIMEOUT     = 15
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_write,
    input  logic [memory_bits-1:0] req_addr,
    input  logic [memory_size-1:0] req_wdata,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [memory_size-1:0] rsp_rdata,
    output logic                   rsp_write,
    output logic                   rsp_error,
    output logic [memory_bits-1:0] fulladdress,
    output logic                   read_signal,
    output logic                   write_signal,
    output logic [memory_size-1:0] out_write,
    input  logic [memory_size-1:0] out_read,
    input  logic [3:0]             state
);

    localparam int unsigned CntW   = $clog2(TIMEOUT + 1);
    localparam int unsigned CountW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CntW-1:0]   TimeoutCnt = CntW'(TIMEOUT);
    localparam logic [CountW-1:0] FullCount  = CountW'(FIFO_DEPTH);

    req_state_e state_q, state_d;
    req_entry_t push_entry, head;
    logic              fifo_full, fifo_empty, fifo_pop;
    logic [CountW-1:0] fifo_count;
    logic              timed_out, completing;

    logic [CntW-1:0]        cnt_q, cnt_d;
    logic                   hold_write_q, hold_write_d;
    logic [memory_bits-1:0] addr_q, addr_d;
    logic [memory_size-1:0] wdata_q, wdata_d;
    logic                   rd_q, rd_d, wr_q, wr_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic                   rsp_error_q, rsp_error_d;
    logic                   rsp_write_q, rsp_write_d;
    logic [memory_size-1:0] rsp_rdata_q, rsp_rdata_d;

    assign push_entry = '{write: req_write, addr: req_addr, wdata: req_wdata};
    // Held low while reset is asserted so nothing is offered before the unit is alive.
    assign req_ready  = reset && (fifo_count != FullCount);

    req_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(req_entry_t))
    ) u_req_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (req_valid && !fifo_full),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign timed_out  = ((state_q == StIssue) || (state_q == StWait)) &&
                        (cnt_q + 1'b1 == TimeoutCnt);
    assign completing = (state_q == StWait) && (state == CACHE_IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= StIdle;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (!fifo_empty) state_d = StIssue;
            StIssue: begin
                if (timed_out)                 state_d = StResp;
                else if (state != CACHE_IDLE)  state_d = StWait;
            end
            StWait:  if (timed_out || completing) state_d = StResp;
            StResp:  if (rsp_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        fifo_pop     = 1'b0;
        cnt_d        = cnt_q;
        hold_write_d = hold_write_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rd_d         = rd_q;
        wr_d         = wr_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_error_d  = rsp_error_q;
        rsp_write_d  = rsp_write_q;
        rsp_rdata_d  = rsp_rdata_q;
        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    fifo_pop     = 1'b1;
                    cnt_d        = '0;
                    hold_write_d = head.write;
                    addr_d       = head.addr;
                    wdata_d      = head.wdata;
                    rd_d         = !head.write;
                    wr_d         = head.write;
                end
            end
            StIssue, StWait: begin
                cnt_d = cnt_q + 1'b1;
                // Timeout wins over a completion seen in the same cycle.
                if (timed_out || completing) begin
                    rd_d        = 1'b0;
                    wr_d        = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_write_d = hold_write_q;
                    rsp_error_d = timed_out;
                    rsp_rdata_d = (timed_out || hold_write_q) ? '0 : out_read;
                end
            end
            StResp:  if (rsp_ready) rsp_valid_d = 1'b0;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q        <= '0;
            hold_write_q <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rd_q         <= 1'b0;
            wr_q         <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_error_q  <= 1'b0;
            rsp_write_q  <= 1'b0;
            rsp_rdata_q  <= '0;
        end else begin
            cnt_q        <= cnt_d;
            hold_write_q <= hold_write_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rd_q         <= rd_d;
            wr_q         <= wr_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_error_q  <= rsp_error_d;
            rsp_write_q  <= rsp_write_d;
            rsp_rdata_q  <= rsp_rdata_d;
        end
    end

    assign fulladdress  = addr_q;
    assign out_write    = wdata_q;
    assign read_signal  = rd_q;
    assign write_signal = wr_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_error    = rsp_error_q;
    assign rsp_write    = rsp_write_q;
    assign rsp_rdata    = rsp_rdata_q;

endmodule

// File: tb/tb_mem_request_unit.sv
// Scoreboard bench for mem_request_unit with a small behavioural cache model.
module tb_mem_request_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_write;
    logic [4:0]  req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid, rsp_ready, rsp_write, rsp_error;
    logic [31:0] rsp_rdata;
    logic [4:0]  fulladdress;
    logic        read_signal, write_signal;
    logic [31:0] out_write, out_read;
    logic [3:0]  cache_state;

    typedef struct packed {
        logic        write;
        logic        error;
        logic [31:0] rdata;
    } rsp_t;

    rsp_t        exp_q[$];
    rsp_t        mon_e;
    int          tests = 0;
    int          fails = 0;
    int          rsp_seen = 0;

    logic [31:0] mem [32];
    logic        cache_stall;
    logic [1:0]  busy;
    logic        served;

    always #5 clk = ~clk;

    mem_request_unit dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_write    (rsp_write),
        .rsp_error    (rsp_error),
        .fulladdress  (fulladdress),
        .read_signal  (read_signal),
        .write_signal (write_signal),
        .out_write    (out_write),
        .out_read     (out_read),
        .state        (cache_state)
    );

    // Cache model: busy (non-zero state) for 3 cycles per access, then idle with data.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            cache_state <= 4'd0;
            busy        <= 2'd0;
            served      <= 1'b0;
            out_read    <= 32'd0;
            for (int i = 0; i < 32; i++) mem[i] <= 32'hC0DE_0000 | 32'(i);
            mem[3] <= 32'hDEAD_BEEF;
        end else if (cache_stall) begin
            cache_state <= 4'd0;
            busy        <= 2'd0;
        end else if (busy != 2'd0) begin
            busy <= busy - 2'd1;
            if (busy == 2'd1) begin
                cache_state <= 4'd0;
                served      <= 1'b1;
                if (write_signal) mem[fulladdress] <= out_write;
                else              out_read <= mem[fulladdress];
            end
        end else if (!read_signal && !write_signal) begin
            served <= 1'b0;
        end else if (!served) begin
            cache_state <= 4'd2;
            busy        <= 2'd3;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor samples just after the falling edge, once bench inputs have settled.
    always @(negedge clk) begin
        #2;
        if (reset && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_rsp: got write=%0b error=%0b rdata=%h, expected none",
                         rsp_write, rsp_error, rsp_rdata);
            end else begin
                mon_e = exp_q.pop_front();
                rsp_seen++;
                check("rsp_write", {31'd0, rsp_write}, {31'd0, mon_e.write});
                check("rsp_error", {31'd0, rsp_error}, {31'd0, mon_e.error});
                check("rsp_rdata", rsp_rdata, mon_e.rdata);
            end
        end
    end

    // Call at a falling edge; returns at the falling edge after the accepting rising edge.
    task automatic send(input logic w, input logic [4:0] a, input logic [31:0] d,
                        input logic [31:0] exp_rdata, input logic exp_err);
        int n = 0;
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            check("send_accept", {31'd0, req_ready}, 32'd1);
        end else begin
            exp_q.push_back('{write: w, error: exp_err, rdata: exp_rdata});
            @(negedge clk);
        end
        req_valid = 1'b0;
    endtask

    task automatic wait_access(input string name);
        int n = 0;
        while (!(read_signal || write_signal) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check(name, {31'd0, read_signal || write_signal}, 32'd1);
    endtask

    task automatic count_high(output int n);
        n = 0;
        while ((read_signal || write_signal) && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check(name, exp_q.size(), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        int  base;
        bit  ok;
        bit  saw;
        req_valid   = 1'b0;
        req_write   = 1'b0;
        req_addr    = 5'd0;
        req_wdata   = 32'd0;
        rsp_ready   = 1'b1;
        cache_stall = 1'b0;
        reset       = 1'b0;
        repeat (3) @(negedge clk);
        check("ready_in_reset", {31'd0, req_ready}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rd_wr", {30'd0, read_signal, write_signal}, 32'd0);
        check("rst_fulladdress", {27'd0, fulladdress}, 32'd0);
        check("rst_out_write", out_write, 32'd0);
        check("rst_rsp_fields", {30'd0, rsp_write, rsp_error}, 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);

        // Single load
        send(1'b0, 5'h03, 32'd0, 32'hDEAD_BEEF, 1'b0);
        wait_access("load_access");
        check("load_addr", {27'd0, fulladdress}, 32'h03);
        check("load_rd_wr", {30'd0, read_signal, write_signal}, 32'b10);
        count_high(n);
        check("load_rd_cycles", n, 32'd5);
        wait_drain("load_drain");

        // Store then read back
        send(1'b1, 5'h1A, 32'h0000_00A5, 32'd0, 1'b0);
        wait_access("store_access");
        check("store_addr", {27'd0, fulladdress}, 32'h1A);
        check("store_rd_wr", {30'd0, read_signal, write_signal}, 32'b01);
        check("store_wdata", out_write, 32'h0000_00A5);
        wait_drain("store_drain");
        send(1'b0, 5'h1A, 32'd0, 32'h0000_00A5, 1'b0);
        wait_drain("readback_drain");
        check("idle_rd_wr", {30'd0, read_signal, write_signal}, 32'd0);
        check("idle_addr_kept", {27'd0, fulladdress}, 32'h1A);

        // Backpressure with a second request waiting
        rsp_ready = 1'b0;
        send(1'b0, 5'h05, 32'd0, 32'hC0DE_0005, 1'b0);
        send(1'b0, 5'h06, 32'd0, 32'hC0DE_0006, 1'b0);
        n = 0;
        while (!rsp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (!rsp_valid || rsp_rdata !== 32'hC0DE_0005 || read_signal || write_signal)
                ok = 1'b0;
            @(negedge clk);
        end
        check("bp_hold", {31'd0, ok}, 32'd1);
        rsp_ready = 1'b1;
        wait_drain("bp_drain");

        // Timeout with a normal load queued behind it
        cache_stall = 1'b1;
        send(1'b0, 5'h07, 32'd0, 32'd0, 1'b1);
        fork
            send(1'b0, 5'h08, 32'd0, 32'hC0DE_0008, 1'b0);
            begin
                wait_access("to_access");
                count_high(n);
            end
        join
        check("to_cycles", n, 32'd15);
        check("to_signals_drop", {30'd0, read_signal, write_signal}, 32'd0);
        cache_stall = 1'b0;
        wait_drain("to_drain");

        // FIFO full: one request in flight plus four buffered
        cache_stall = 1'b1;
        for (int i = 0; i < 5; i++)
            send(1'((i % 3) != 0), 5'(16 + i), 32'(i), 32'd0, 1'b1);
        check("full_ready_low", {31'd0, req_ready}, 32'd0);
        base = rsp_seen;
        send(1'b1, 5'd21, 32'd5, 32'd0, 1'b1);
        check("full_sixth_after_pop", {31'd0, rsp_seen > base}, 32'd1);
        wait_drain("full_drain");
        cache_stall = 1'b0;

        // Reset in the middle of a cache access
        send(1'b0, 5'h09, 32'd0, 32'hC0DE_0009, 1'b0);
        send(1'b0, 5'h0A, 32'd0, 32'hC0DE_000A, 1'b0);
        n = 0;
        while (cache_state == 4'd0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check("mid_read_active", {31'd0, read_signal}, 32'd1);
        reset = 1'b0;
        #1;
        check("mid_rst_rd_wr", {30'd0, read_signal, write_signal}, 32'd0);
        check("mid_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("mid_rst_ready", {31'd0, req_ready}, 32'd0);
        exp_q.delete();
        @(negedge clk);
        reset = 1'b1;
        saw = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (read_signal || write_signal || rsp_valid) saw = 1'b1;
        end
        check("post_rst_quiet", {31'd0, saw}, 32'd0);
        check("post_rst_ready", {31'd0, req_ready}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
